// File: rtl/clock_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// clock_pkg : shared types and helpers for multi_alarm_clock  (rev 1.0)
// ----------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [1:0] {
      OFF      = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZING = 2'd3
   } alarm_state_t;

   localparam logic [1:0] SEL_SEC  = 2'd0;
   localparam logic [1:0] SEL_MIN  = 2'd1;
   localparam logic [1:0] SEL_HOUR = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   // (a + b) mod m, valid while both operands are already below m
   function automatic int unsigned mod_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned m);
      int unsigned s;
      s = a + b;
      if (s >= m) s = s - m;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_channel.sv
`default_nettype none
// ----------------------------------------------------------------------
// alarm_channel : one alarm slot with arm / ring / snooze / dismiss  (rev 1.0)
// ----------------------------------------------------------------------
module alarm_channel
   import clock_pkg::*;
#(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned MIN_RANGE   = 60,
   parameter int unsigned HOUR_RANGE  = 24,
   parameter int unsigned RING_SECS   = 30,
   parameter int unsigned SNOOZE_MINS = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic             run_i,
   input  logic             wr_i,
   input  logic             arm_i,
   input  logic [WIDTH-1:0] wr_hour_i,
   input  logic [WIDTH-1:0] wr_min_i,
   input  logic             snooze_i,
   input  logic             dismiss_i,
   input  logic             adv_i,
   input  logic [WIDTH-1:0] new_hour_i,
   input  logic [WIDTH-1:0] new_min_i,
   input  logic [WIDTH-1:0] cur_hour_i,
   input  logic [WIDTH-1:0] cur_min_i,
   output logic             ring_o
);

   localparam int unsigned CNT_W = $clog2(RING_SECS + 1);

   alarm_state_t     state_q, state_d;
   logic [WIDTH-1:0] tgt_hour_q, tgt_hour_d, tgt_min_q, tgt_min_d;
   logic [WIDTH-1:0] snz_hour_q, snz_hour_d, snz_min_q, snz_min_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] snz_min_w, snz_hour_w;
   logic             hit_tgt_w, hit_snz_w;

   // Minute wrap is detected by the sum landing below the current minute.
   assign snz_min_w  = WIDTH'(mod_add(32'(cur_min_i), SNOOZE_MINS, MIN_RANGE));
   assign snz_hour_w = WIDTH'(mod_add(32'(cur_hour_i),
                                      (snz_min_w < cur_min_i) ? 32'd1 : 32'd0,
                                      HOUR_RANGE));
   assign hit_tgt_w  = adv_i && (new_hour_i == tgt_hour_q) && (new_min_i == tgt_min_q);
   assign hit_snz_w  = adv_i && (new_hour_i == snz_hour_q) && (new_min_i == snz_min_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= OFF;
         tgt_hour_q <= '0;
         tgt_min_q  <= '0;
         snz_hour_q <= '0;
         snz_min_q  <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         tgt_hour_q <= tgt_hour_d;
         tgt_min_q  <= tgt_min_d;
         snz_hour_q <= snz_hour_d;
         snz_min_q  <= snz_min_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tgt_hour_d = tgt_hour_q;
      tgt_min_d  = tgt_min_q;
      snz_hour_d = snz_hour_q;
      snz_min_d  = snz_min_q;
      cnt_d      = cnt_q;
      if (wr_i) begin
         if (arm_i) begin
            state_d    = ARMED;
            tgt_hour_d = wr_hour_i;
            tgt_min_d  = wr_min_i;
         end else begin
            state_d = OFF;
         end
      end else begin
         case (state_q)
            ARMED: begin
               if (hit_tgt_w) begin
                  state_d = RINGING;
                  cnt_d   = '0;
               end
            end
            RINGING: begin
               if (dismiss_i) begin
                  state_d = ARMED;
               end else if (snooze_i) begin
                  state_d    = SNOOZING;
                  snz_hour_d = snz_hour_w;
                  snz_min_d  = snz_min_w;
               end else if (tick_i && run_i) begin
                  if (cnt_q == CNT_W'(RING_SECS - 1)) state_d = ARMED;
                  else                                cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            SNOOZING: begin
               if (dismiss_i) begin
                  state_d = ARMED;
               end else if (hit_snz_w) begin
                  state_d = RINGING;
                  cnt_d   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ring_o = (state_q == RINGING);

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ----------------------------------------------------------------------
// multi_alarm_clock : hh:mm:ss core, hourly chime, ALARM_CH alarms  (rev 1.0)
// ----------------------------------------------------------------------
module multi_alarm_clock
   import clock_pkg::*;
#(
   parameter  int unsigned ALARM_CH    = 4,
   parameter  int unsigned SEC_RANGE   = 60,
   parameter  int unsigned MIN_RANGE   = 60,
   parameter  int unsigned HOUR_RANGE  = 24,
   parameter  int unsigned WIDTH       = 6,
   parameter  int unsigned RING_SECS   = 30,
   parameter  int unsigned SNOOZE_MINS = 5,
   localparam int unsigned IDX_W       = (ALARM_CH > 1) ? $clog2(ALARM_CH) : 1
) (
   input  logic                clk_src_i,
   input  logic                reset_i,
   input  logic                tick_i,
   input  logic                run_i,
   input  logic                set_en_i,
   input  logic [1:0]          set_sel_i,
   input  logic                set_up_i,
   input  logic                set_down_i,
   input  logic                alarm_wr_i,
   input  logic [IDX_W-1:0]    alarm_idx_i,
   input  logic [WIDTH-1:0]    alarm_hour_i,
   input  logic [WIDTH-1:0]    alarm_min_i,
   input  logic                alarm_arm_i,
   input  logic                snooze_i,
   input  logic                dismiss_i,
   output logic [WIDTH-1:0]    sec_o,
   output logic [WIDTH-1:0]    min_o,
   output logic [WIDTH-1:0]    hour_o,
   output logic                chime_o,
   output logic [ALARM_CH-1:0] ring_o,
   output logic                ring_any_o
);

   logic [WIDTH-1:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic                chime_q, chime_d;
   logic                adv_w;
   logic [ALARM_CH-1:0] ring_w;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                             input logic             up,
                                             input int unsigned      range);
      if (up) return (v == WIDTH'(range - 1)) ? '0 : v + WIDTH'(1);
      else    return (v == '0) ? WIDTH'(range - 1) : v - WIDTH'(1);
   endfunction

   always_ff @(posedge clk_src_i or posedge reset_i) begin
      if (reset_i) begin
         sec_q   <= '0;
         min_q   <= '0;
         hour_q  <= '0;
         chime_q <= 1'b0;
      end else begin
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         chime_q <= chime_d;
      end
   end

   // Adjust mode owns the counters outright; ticks seen meanwhile are lost.
   always_comb begin
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      chime_d = 1'b0;
      adv_w   = 1'b0;
      if (set_en_i) begin
         if (set_up_i ^ set_down_i) begin
            case (set_sel_i)
               SEL_SEC:  sec_d  = step(sec_q,  set_up_i, SEC_RANGE);
               SEL_MIN:  min_d  = step(min_q,  set_up_i, MIN_RANGE);
               SEL_HOUR: hour_d = step(hour_q, set_up_i, HOUR_RANGE);
               default: ;
            endcase
         end
      end else if (tick_i && run_i) begin
         if (sec_q == WIDTH'(SEC_RANGE - 1)) begin
            sec_d = '0;
            adv_w = 1'b1;
            if (min_q == WIDTH'(MIN_RANGE - 1)) begin
               min_d   = '0;
               chime_d = 1'b1;
               hour_d  = step(hour_q, 1'b1, HOUR_RANGE);
            end else begin
               min_d = step(min_q, 1'b1, MIN_RANGE);
            end
         end else begin
            sec_d = step(sec_q, 1'b1, SEC_RANGE);
         end
      end
   end

   // Out-of-range indices simply match no channel.
   for (genvar gi = 0; gi < ALARM_CH; gi++) begin : g_ch
      alarm_channel #(
         .WIDTH       (WIDTH),
         .MIN_RANGE   (MIN_RANGE),
         .HOUR_RANGE  (HOUR_RANGE),
         .RING_SECS   (RING_SECS),
         .SNOOZE_MINS (SNOOZE_MINS)
      ) u_ch (
         .clk_i      (clk_src_i),
         .rst_i      (reset_i),
         .tick_i     (tick_i),
         .run_i      (run_i),
         .wr_i       (alarm_wr_i && (alarm_idx_i == IDX_W'(gi))),
         .arm_i      (alarm_arm_i),
         .wr_hour_i  (alarm_hour_i),
         .wr_min_i   (alarm_min_i),
         .snooze_i   (snooze_i),
         .dismiss_i  (dismiss_i),
         .adv_i      (adv_w),
         .new_hour_i (hour_d),
         .new_min_i  (min_d),
         .cur_hour_i (hour_q),
         .cur_min_i  (min_q),
         .ring_o     (ring_w[gi])
      );
   end

   assign sec_o      = sec_q;
   assign min_o      = min_q;
   assign hour_o     = hour_q;
   assign chime_o    = chime_q;
   assign ring_o     = ring_w;
   assign ring_any_o = |ring_w;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_multi_alarm_clock : directed stimulus against a seconds-of-day model  (rev 1.0)
// ----------------------------------------------------------------------
module tb_multi_alarm_clock;

   localparam int ALARM_CH = 4, SEC_RANGE = 60, MIN_RANGE = 60, HOUR_RANGE = 24;
   localparam int WIDTH = 6, RING_SECS = 30, SNOOZE_MINS = 5, IDX_W = 2;
   localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;
   localparam int DAY_MINS = HOUR_RANGE * MIN_RANGE;

   logic clk = 1'b0, rst = 1'b0, tick = 1'b0, run = 1'b0;
   logic set_en = 1'b0, set_up = 1'b0, set_down = 1'b0;
   logic [1:0] set_sel = 2'd3;
   logic alarm_wr = 1'b0, alarm_arm = 1'b0, snooze = 1'b0, dismiss = 1'b0;
   logic [IDX_W-1:0] alarm_idx = '0;
   logic [WIDTH-1:0] alarm_hour = '0, alarm_min = '0;
   logic [WIDTH-1:0] sec, mins, hour;
   logic chime, ring_any;
   logic [ALARM_CH-1:0] ring;

   int total = 0, bad = 0, chime_seen = 0;
   bit chk_en = 1'b0;

   // reference model state: time fields plus per-channel mode and minute-of-day targets
   int m_sec = 0, m_min = 0, m_hour = 0;
   bit m_chime = 1'b0;
   int mode[ALARM_CH], tgt[ALARM_CH], snz[ALARM_CH], cnt[ALARM_CH];
   int t, cur_mod, new_mod, d;
   bit adv;
   logic [ALARM_CH-1:0] exp_ring;

   multi_alarm_clock #(
      .ALARM_CH(ALARM_CH), .SEC_RANGE(SEC_RANGE), .MIN_RANGE(MIN_RANGE),
      .HOUR_RANGE(HOUR_RANGE), .WIDTH(WIDTH), .RING_SECS(RING_SECS),
      .SNOOZE_MINS(SNOOZE_MINS)
   ) dut (
      .clk_src_i(clk), .reset_i(rst), .tick_i(tick), .run_i(run),
      .set_en_i(set_en), .set_sel_i(set_sel), .set_up_i(set_up), .set_down_i(set_down),
      .alarm_wr_i(alarm_wr), .alarm_idx_i(alarm_idx), .alarm_hour_i(alarm_hour),
      .alarm_min_i(alarm_min), .alarm_arm_i(alarm_arm), .snooze_i(snooze),
      .dismiss_i(dismiss), .sec_o(sec), .min_o(mins), .hour_o(hour),
      .chime_o(chime), .ring_o(ring), .ring_any_o(ring_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: advance is whole-day seconds arithmetic, alarms compare minute-of-day
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_sec = 0; m_min = 0; m_hour = 0; m_chime = 1'b0;
         for (int i = 0; i < ALARM_CH; i++) begin
            mode[i] = M_OFF; tgt[i] = 0; snz[i] = 0; cnt[i] = 0;
         end
      end else begin
         cur_mod = m_hour * MIN_RANGE + m_min;
         adv = 1'b0;
         m_chime = 1'b0;
         if (set_en) begin
            if (set_up != set_down) begin
               d = set_up ? 1 : -1;
               case (set_sel)
                  2'd0: m_sec  = (m_sec  + d + SEC_RANGE)  % SEC_RANGE;
                  2'd1: m_min  = (m_min  + d + MIN_RANGE)  % MIN_RANGE;
                  2'd2: m_hour = (m_hour + d + HOUR_RANGE) % HOUR_RANGE;
                  default: ;
               endcase
            end
         end else if (tick && run) begin
            t = (cur_mod * SEC_RANGE + m_sec + 1) % (DAY_MINS * SEC_RANGE);
            m_sec  = t % SEC_RANGE;
            m_min  = (t / SEC_RANGE) % MIN_RANGE;
            m_hour = t / (SEC_RANGE * MIN_RANGE);
            adv = (m_sec == 0);
            m_chime = adv && (m_min == 0);
         end
         new_mod = m_hour * MIN_RANGE + m_min;
         for (int i = 0; i < ALARM_CH; i++) begin
            if (alarm_wr && int'(alarm_idx) == i) begin
               if (alarm_arm) begin
                  mode[i] = M_ARMED;
                  tgt[i] = int'(alarm_hour) * MIN_RANGE + int'(alarm_min);
               end else mode[i] = M_OFF;
            end else if (dismiss && (mode[i] == M_RING || mode[i] == M_SNZ)) begin
               mode[i] = M_ARMED;
            end else if (snooze && mode[i] == M_RING) begin
               mode[i] = M_SNZ;
               snz[i] = (cur_mod + SNOOZE_MINS) % DAY_MINS;
            end else if (mode[i] == M_RING && tick && run) begin
               cnt[i]++;
               if (cnt[i] == RING_SECS) mode[i] = M_ARMED;
            end else if (adv && mode[i] == M_ARMED && new_mod == tgt[i]) begin
               mode[i] = M_RING; cnt[i] = 0;
            end else if (adv && mode[i] == M_SNZ && new_mod == snz[i]) begin
               mode[i] = M_RING; cnt[i] = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < ALARM_CH; i++) exp_ring[i] = (mode[i] == M_RING);
         check("sec", 32'(sec), m_sec);
         check("min", 32'(mins), m_min);
         check("hour", 32'(hour), m_hour);
         check("chime", 32'(chime), 32'(m_chime));
         check("ring", 32'(ring), 32'(exp_ring));
         check("ring_any", 32'(ring_any), 32'(|exp_ring));
         if (chime === 1'b1) chime_seen++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish by %0t", $time);
      $fatal(1);
   end

   task automatic do_ticks(input int n);
      repeat (n) begin
         @(negedge clk) tick = 1'b1;
         @(negedge clk) tick = 1'b0;
      end
   endtask

   task automatic adjust(input logic [1:0] sel, input logic up);
      @(negedge clk);
      set_sel = sel; set_up = up; set_down = !up;
      @(negedge clk);
      set_up = 1'b0; set_down = 1'b0;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      @(negedge clk) set_en = 1'b1;
      for (int k = 0; k < 64 && m_hour != h; k++) adjust(2'd2, 1'b1);
      for (int k = 0; k < 64 && m_min  != m; k++) adjust(2'd1, 1'b1);
      for (int k = 0; k < 64 && m_sec  != s; k++) adjust(2'd0, 1'b1);
      @(negedge clk) set_en = 1'b0;
   endtask

   task automatic alarm_cmd(input int idx, input int h, input int m, input logic arm);
      @(negedge clk);
      alarm_idx = IDX_W'(idx); alarm_hour = WIDTH'(h); alarm_min = WIDTH'(m);
      alarm_arm = arm; alarm_wr = 1'b1;
      @(negedge clk) alarm_wr = 1'b0;
   endtask

   task automatic pulse_snooze();
      @(negedge clk) snooze = 1'b1;
      @(negedge clk) snooze = 1'b0;
   endtask

   task automatic pulse_dismiss();
      @(negedge clk) dismiss = 1'b1;
      @(negedge clk) dismiss = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_sec", 32'(sec), 0);
      check("rst_hour", 32'(hour), 0);
      check("rst_ring", 32'(ring), 0);

      // one hour, one minute, one second from midnight
      run = 1'b1;
      chime_seen = 0;
      do_ticks(3661);
      check("t1_hour", 32'(hour), 1);
      check("t1_min", 32'(mins), 1);
      check("t1_sec", 32'(sec), 1);
      check("t1_chimes", chime_seen, 1);

      // midnight rollover
      set_time(23, 59, 59);
      do_ticks(1);
      check("t2_hms", {8'd0, 2'b0, hour, 2'b0, mins, 2'b0, sec}, 0);
      check("t2_chime_on", 32'(chime), 1);
      @(negedge clk);
      check("t2_chime_off", 32'(chime), 0);

      // minute borrow does not touch hour; ticks in adjust mode are dropped
      @(negedge clk) set_en = 1'b1;
      adjust(2'd1, 1'b0);
      check("t3_min_wrap", 32'(mins), 59);
      check("t3_hour_kept", 32'(hour), 0);
      do_ticks(5);
      check("t3_ticks_dropped", 32'(sec), 0);
      @(negedge clk) set_en = 1'b0;

      // ring, timeout back to armed, re-fire
      alarm_cmd(2, 7, 30, 1'b1);
      set_time(7, 29, 59);
      do_ticks(1);
      check("t4_ring_on", 32'(ring), 32'h4);
      do_ticks(29);
      check("t4_ring_29", 32'(ring), 32'h4);
      do_ticks(1);
      check("t4_timeout", 32'(ring), 0);
      set_time(7, 29, 59);
      do_ticks(1);
      check("t4_rearmed", 32'(ring), 32'h4);
      pulse_dismiss();
      check("t4_dismissed", 32'(ring), 0);

      // snooze across midnight
      alarm_cmd(0, 23, 58, 1'b1);
      set_time(23, 57, 59);
      do_ticks(1);
      check("t5_ring", 32'(ring), 32'h1);
      pulse_snooze();
      check("t5_snoozed", 32'(ring), 0);
      do_ticks(299);
      check("t5_before", 32'(ring), 0);
      do_ticks(1);
      check("t5_resume", 32'(ring), 32'h1);
      check("t5_time", {16'd0, 2'b0, hour, 2'b0, mins}, {16'd0, 8'd0, 8'd3});
      pulse_dismiss();
      check("t5_dismiss", 32'(ring), 0);
      do_ticks(300);
      check("t5_no_ring_0008", 32'(ring), 0);
      check("t5_min_0008", 32'(mins), 8);

      // two channels together, write-off plus dismiss, async reset
      alarm_cmd(0, 6, 0, 1'b1);
      alarm_cmd(1, 6, 0, 1'b1);
      set_time(5, 59, 59);
      do_ticks(1);
      check("t6_both", 32'(ring), 32'h3);
      check("t6_any", 32'(ring_any), 1);
      @(negedge clk);
      alarm_idx = IDX_W'(1); alarm_arm = 1'b0; alarm_wr = 1'b1; dismiss = 1'b1;
      @(negedge clk);
      alarm_wr = 1'b0; dismiss = 1'b0;
      check("t6_cleared", 32'(ring), 0);
      set_time(5, 59, 59);
      do_ticks(1);
      check("t6_ch1_off", 32'(ring), 32'h1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t6_async_ring", 32'(ring), 0);
      check("t6_async_any", 32'(ring_any), 0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      do_ticks(2);
      check("t6_after_reset", 32'(sec), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
